mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_timeout_ctr.sv | 36 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW     = 32;
  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefStarveMax = 4;
  localparam int unsigned DefTimeout   = 255;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } arb_state_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Per-access watchdog: counts BUSY cycles without an ack and flags the last allowed cycle.
module arb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // High during the TIMEOUT-th waiting cycle, so the access ends on that edge.
  assign expired_o = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-port memory,
// data first with a bounded starvation streak for fetch, plus a per-access timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned STARVE_MAX = DefStarveMax,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  localparam int unsigned StrW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [StrW-1:0]   streak_q, streak_d;

  logic i_elig, d_elig, at_max;
  logic tmo_clear, tmo_en, tmo_expired;

  // A requester still sees its own done this cycle; it must not be re-granted yet.
  assign i_elig = i_req & ~i_done_q;
  assign d_elig = d_req & ~d_done_q;
  assign at_max = (streak_q == StrW'(STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    streak_d    = streak_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = 1'b0;
    tmo_clear   = 1'b0;
    tmo_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_elig && !(i_elig && at_max)) begin
          state_d     = StBusyD;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          tmo_clear   = 1'b1;
          if (!i_req) begin
            streak_d = '0;
          end else if (!at_max) begin
            streak_d = streak_q + StrW'(1);
          end
        end else if (i_elig) begin
          state_d    = StBusyI;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          tmo_clear  = 1'b1;
          streak_d   = '0;
        end
      end

      StBusyI, StBusyD: begin
        // An ack on the expiry edge wins: the access completes normally.
        if (mem_ack || tmo_expired) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = ~mem_ack;
          if (state_q == StBusyI) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else begin
          tmo_en = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
      streak_q    <= streak_d;
    end
  end

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clear_i  (tmo_clear),
    .enable_i (tmo_en),
    .expired_o(tmo_expired)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int TO = 255;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        i_done, d_done, mem_req, mem_we, bus_err, mem_ack;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(SM),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .bus_err  (bus_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack on the lat-th cycle of a request; lat == 0 never acks.
  int   lat = 1;
  int   seen = 0;
  logic [31:0] rd_val = '0;
  logic resp_ack = 1'b0, stray_ack = 1'b0;
  assign mem_ack = resp_ack | stray_ack;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      resp_ack = 1'b0;
      seen     = 0;
    end else if (mem_req && !resp_ack && lat > 0) begin
      seen++;
      if (seen == lat) begin
        resp_ack  = 1'b1;
        mem_rdata = rd_val;
      end
    end else begin
      resp_ack = 1'b0;
      seen     = 0;
    end
  end

  // Reference model: owner 0 = none, 1 = fetch, 2 = data.
  int          m_owner = 0, m_wait = 0, m_streak = 0;
  logic        e_mem_req = 0, e_mem_we = 0, e_i_done = 0, e_d_done = 0, e_bus_err = 0;
  logic [31:0] e_mem_addr = '0, e_mem_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;

  always @(posedge clk or negedge reset) begin
    logic pi, pd, ei, ed;
    if (!reset) begin
      m_owner = 0; m_wait = 0; m_streak = 0;
      e_mem_req = 0; e_mem_we = 0; e_i_done = 0; e_d_done = 0; e_bus_err = 0;
      e_mem_addr = '0; e_mem_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
    end else begin
      pi = e_i_done;
      pd = e_d_done;
      e_i_done = 0; e_d_done = 0; e_bus_err = 0;
      if (m_owner != 0) begin
        if (mem_ack || m_wait + 1 == TO) begin
          if (m_owner == 1) begin
            e_i_done  = 1;
            e_i_rdata = mem_ack ? mem_rdata : 32'h0;
          end else begin
            e_d_done  = 1;
            e_d_rdata = mem_ack ? mem_rdata : 32'h0;
          end
          e_bus_err = !mem_ack;
          e_mem_req = 0;
          e_mem_we  = 0;
          m_owner   = 0;
        end else begin
          m_wait++;
        end
      end else begin
        ei = i_req && !pi;
        ed = d_req && !pd;
        if (ed && (!ei || m_streak < SM)) begin
          m_owner     = 2;
          m_streak    = i_req ? ((m_streak < SM) ? m_streak + 1 : SM) : 0;
          e_mem_req   = 1;
          e_mem_we    = d_we;
          e_mem_addr  = d_addr;
          e_mem_wdata = d_wdata;
          m_wait      = 0;
        end else if (ei) begin
          m_owner    = 1;
          m_streak   = 0;
          e_mem_req  = 1;
          e_mem_we   = 0;
          e_mem_addr = i_addr;
          m_wait     = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_req", 64'(mem_req), 64'(e_mem_req));
    chk("mem_we", 64'(mem_we), 64'(e_mem_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_mem_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_mem_wdata));
    chk("i_done", 64'(i_done), 64'(e_i_done));
    chk("d_done", 64'(d_done), 64'(e_d_done));
    chk("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
    chk("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
    chk("bus_err", 64'(bus_err), 64'(e_bus_err));
  end

  // Grant log: one entry per rising mem_req.
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;
  grant_t glog[$];
  logic   prev_req = 1'b0;

  always @(negedge clk) begin
    if (mem_req && !prev_req) glog.push_back('{addr: mem_addr, we: mem_we, wdata: mem_wdata});
    prev_req = mem_req;
  end

  task automatic settle();
    i_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!mem_req && !i_done && !d_done) break;
    end
    chk("settle_idle", 64'(mem_req), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    int nreq, ndone, done_at, run, maxrun;
    bit saw_done;
    logic [31:0] exp_g [6];

    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_d_rdata", 64'(d_rdata), 64'(0));
    #2 reset = 1'b1;

    // Fetch at 0x40, ack on third request cycle.
    glog.delete();
    lat = 3;
    rd_val = 32'h0050_0093;
    @(negedge clk);
    i_addr = 32'h40;
    i_req  = 1'b1;
    nreq = 0; ndone = 0; done_at = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (i_done) begin
        ndone++;
        if (done_at < 0) done_at = k;
        i_req = 1'b0;
        chk("fetch_rdata", 64'(i_rdata), 64'h0050_0093);
      end
    end
    chk("fetch_req_cycles", 64'(nreq), 64'(3));
    chk("fetch_done_cycle", 64'(done_at), 64'(4));
    chk("fetch_done_count", 64'(ndone), 64'(1));
    chk("fetch_rdata_hold", 64'(i_rdata), 64'h0050_0093);
    chk("fetch_grant_addr", 64'(glog[0].addr), 64'h40);
    settle();

    // Simultaneous store and fetch: store goes first.
    glog.delete();
    lat = 2;
    rd_val = 32'h1111_2222;
    @(negedge clk);
    i_addr = 32'h80; i_req = 1'b1;
    d_we = 1'b1; d_addr = 32'd212; d_wdata = 32'd511; d_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_done) d_req = 1'b0;
      if (i_done) begin
        i_req = 1'b0;
        break;
      end
    end
    chk("both_grants", 64'(glog.size()), 64'(2));
    chk("store_addr", 64'(glog[0].addr), 64'd212);
    chk("store_we", 64'(glog[0].we), 64'(1));
    chk("store_wdata", 64'(glog[0].wdata), 64'd511);
    chk("fetch2_addr", 64'(glog[1].addr), 64'h80);
    chk("fetch2_we", 64'(glog[1].we), 64'(0));
    settle();

    // Starvation bound: fetch waits whenever data is not in its done cycle.
    glog.delete();
    lat = 1;
    rd_val = 32'hCAFE_0001;
    i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; d_wdata = '0;
    @(negedge clk);
    d_req = 1'b1;
    i_req = 1'b1;
    repeat (30) begin
      @(negedge clk);
      i_req = !d_done;
    end
    settle();
    exp_g = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100, 32'h200};
    for (int g = 0; g < 6; g++) chk($sformatf("starve_grant%0d", g), 64'(glog[g].addr),
                                     64'(exp_g[g]));
    run = 0; maxrun = 0;
    foreach (glog[g]) begin
      run = (glog[g].addr == 32'h200) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    chk("max_d_run", 64'(maxrun), 64'(SM));

    // Load that is never acked: times out after TO busy cycles.
    lat = 0;
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
    done_at = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (d_done) begin
        done_at = k;
        chk("tmo_rdata", 64'(d_rdata), 64'(0));
        chk("tmo_bus_err", 64'(bus_err), 64'(1));
        chk("tmo_mem_req", 64'(mem_req), 64'(0));
        d_req = 1'b0;
        break;
      end
    end
    chk("tmo_cycle", 64'(done_at), 64'(256));
    settle();

    // Ack lands on the expiry edge: normal completion.
    lat = TO;
    rd_val = 32'h1234_5678;
    @(negedge clk);
    d_addr = 32'h304; d_req = 1'b1;
    done_at = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (d_done) begin
        done_at = k;
        chk("late_ack_rdata", 64'(d_rdata), 64'h1234_5678);
        chk("late_ack_no_err", 64'(bus_err), 64'(0));
        d_req = 1'b0;
        break;
      end
    end
    chk("late_ack_cycle", 64'(done_at), 64'(256));
    settle();

    // Stray ack while idle is ignored.
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_mem_req", 64'(mem_req), 64'(0));
    chk("stray_d_done", 64'(d_done), 64'(0));
    chk("stray_i_done", 64'(i_done), 64'(0));

    // Reset during a data access abandons it; held request is re-granted after.
    lat = 0;
    d_addr = 32'h308; d_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 64'(mem_req), 64'(1));
    #2 reset = 1'b0;
    #1 chk("rst_async_mem_req", 64'(mem_req), 64'(0));
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (d_done) saw_done = 1'b1;
    end
    chk("rst_no_done", 64'(saw_done), 64'(0));
    lat = 2;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_regrant", 64'(mem_req), 64'(1));
    chk("post_rst_addr", 64'(mem_addr), 64'h308);
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_done) begin
        saw_done = 1'b1;
        d_req = 1'b0;
        break;
      end
    end
    chk("post_rst_done", 64'(saw_done), 64'(1));
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
